mips_multicycle: RTL and testbench

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

---
 rtl/mips_multicycle.sv | 180 ++++++++++++++++++
 tb/tb_mips_multicycle.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core with word-addressed IMEM/DMEM and a host load port.
// Define MIPS_JUMP_EN to add the j instruction (opcode 0x02); otherwise j halts in DECODE.
module mips_multicycle #(
   parameter int          IMEM_WORDS = 1024,
   parameter int          DMEM_WORDS = 1024,
   parameter logic [31:0] PC_RESET   = 32'h0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        run,
   input  logic        ld_we,
   input  logic        ld_sel,
   input  logic [9:0]  ld_addr,
   input  logic [31:0] ld_wdata,
   input  logic [4:0]  dbg_raddr,
   output logic [31:0] dbg_rdata,
   output logic [31:0] IR,
   output logic [31:0] WD,
   output logic [31:0] pc,
   output logic [2:0]  state,
   output logic        halted,
   output logic [31:0] retired
);

`ifdef MIPS_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif
   localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
   localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
      S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
   } state_t;

   typedef enum logic [2:0] {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_BAD} op_t;

   state_t      st, st_nx;
   op_t         op;
   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];
   logic [31:0] regs [32];
   logic [31:0] a, b, imm, alu_out, mdr, alu_res, wb_data;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, wb_dest;
   logic        fetch_bad, dmem_bad, ld_ok, done, taken;

   assign opcode    = IR[31:26];
   assign rs        = IR[25:21];
   assign rt        = IR[20:16];
   assign rd        = IR[15:11];
   assign funct     = IR[5:0];
   assign state     = st;
   assign halted    = (st == S_HALT);
   assign dbg_rdata = regs[dbg_raddr];

   assign fetch_bad = ({2'b00, pc[31:2]} >= 32'(IMEM_WORDS)) || (pc[1:0] != 2'b00);
   assign dmem_bad  = ({2'b00, alu_res[31:2]} >= 32'(DMEM_WORDS));
   assign taken     = ((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b));
   assign wb_data   = (op == OP_LW) ? mdr : alu_out;
   assign wb_dest   = (op == OP_R) ? rd : rt;
   assign ld_ok     = ld_we && ((st == S_IDLE) || (st == S_HALT));

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      op = OP_BAD;
      case (opcode)
         6'h00: begin
            case (funct)
               6'd32, 6'd34, 6'd36, 6'd37, 6'd42: op = OP_R;
               default: op = OP_BAD;
            endcase
         end
         6'h23:   op = OP_LW;
         6'h2B:   op = OP_SW;
         6'h04:   op = OP_BEQ;
         6'h05:   op = OP_BNE;
         6'h08:   op = OP_ADDI;
         6'h02:   op = JUMP_EN ? OP_J : OP_BAD;
         default: op = OP_BAD;
      endcase
   end

   always_comb begin
      alu_res = a + imm;
      if (op == OP_R) begin
         case (funct)
            6'd34:   alu_res = a - b;
            6'd36:   alu_res = a & b;
            6'd37:   alu_res = a | b;
            6'd42:   alu_res = {31'd0, $signed(a) < $signed(b)};
            default: alu_res = a + b;
         endcase
      end
   end

   always_comb begin
      st_nx = st;
      done  = 1'b0;
      case (st)
         S_IDLE:   if (run) st_nx = S_FETCH;
         S_FETCH:  st_nx = fetch_bad ? S_HALT : S_DECODE;
         S_DECODE: st_nx = (op == OP_BAD) ? S_HALT : S_EXEC;
         S_EXEC: begin
            case (op)
               OP_LW, OP_SW:  st_nx = dmem_bad ? S_HALT : S_MEM;
               OP_R, OP_ADDI: st_nx = S_WB;
               default:       done  = 1'b1;
            endcase
         end
         S_MEM: begin
            if (op == OP_LW) st_nx = S_WB;
            else             done  = 1'b1;
         end
         S_WB:    done  = 1'b1;
         default: st_nx = S_HALT;
      endcase
      if (done) st_nx = run ? S_FETCH : S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) st <= S_IDLE;
      else          st <= st_nx;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc      <= PC_RESET;
         IR      <= '0;
         WD      <= '0;
         retired <= '0;
         a       <= '0;
         b       <= '0;
         imm     <= '0;
         alu_out <= '0;
         mdr     <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         if (done && (retired != '1)) retired <= retired + 32'd1;
         case (st)
            S_FETCH: begin
               if (!fetch_bad) begin
                  IR <= imem[pc[IAW+1:2]];
                  pc <= pc + 32'd4;
               end
            end
            S_DECODE: begin
               a   <= regs[rs];
               b   <= regs[rt];
               imm <= {{16{IR[15]}}, IR[15:0]};
            end
            S_EXEC: begin
               alu_out <= alu_res;
               if (taken)       pc <= pc + (imm << 2);
               if (op == OP_J)  pc <= {pc[31:28], IR[25:0], 2'b00};
            end
            S_MEM: if (op == OP_LW) mdr <= dmem[alu_out[DAW+1:2]];
            S_WB: begin
               WD <= wb_data;
               if (wb_dest != 5'd0) regs[wb_dest] <= wb_data;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the memories carry no reset so program and data survive reset_n; an aborted sw
   // cannot land because reset forces the FSM out of MEM before the next edge.
   always_ff @(posedge clock) begin
      if (ld_ok && !ld_sel && (32'(ld_addr) < IMEM_WORDS)) imem[IAW'(ld_addr)] <= ld_wdata;
      if (ld_ok && ld_sel && (32'(ld_addr) < DMEM_WORDS))
         dmem[DAW'(ld_addr)] <= ld_wdata;
      else if ((st == S_MEM) && (op == OP_SW))
         dmem[alu_out[DAW+1:2]] <= b;
   end

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: table of short programs plus hand-written
// sequences for swap, cycle counts, run drop, bad addresses, mid-instruction reset and jump.
module tb_mips_multicycle;

   localparam logic [31:0] HW = 32'hFC00_0000;

   logic        clock = 1'b0, reset_n = 1'b0, run = 1'b0, ld_we = 1'b0, ld_sel = 1'b0;
   logic [9:0]  ld_addr = '0;
   logic [31:0] ld_wdata = '0;
   logic [4:0]  dbg_raddr = '0;
   logic [31:0] dbg_rdata, IR, WD, pc, retired;
   logic [2:0]  state;
   logic        halted;

   int checks = 0;
   int errors = 0;

   mips_multicycle dut (
      .clock(clock), .reset_n(reset_n), .run(run), .ld_we(ld_we), .ld_sel(ld_sel),
      .ld_addr(ld_addr), .ld_wdata(ld_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
      .IR(IR), .WD(WD), .pc(pc), .state(state), .halted(halted), .retired(retired)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0][31:0] prog;
      logic [4:0]       rd;
      logic [31:0]      val;
      logic [31:0]      ret;
   } vec_t;

   vec_t        vecs [12];
   vec_t        exp_q [$];
   vec_t        e;
   logic [31:0] wd_q [$];
   int          st_q [$];
   int          cyc;
   logic        sb_en = 1'b0;
   logic        wb_seen = 1'b0;

   function automatic logic [31:0] ri(input int f, input int rs, input int rt, input int rd);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, f[5:0]};
   endfunction

   function automatic logic [31:0] ii(input int op, input int rs, input int rt, input int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                               input logic [31:0] w3, input int rd, input logic [31:0] val,
                               input int ret);
      vec_t v;
      v.prog[0] = w0;
      v.prog[1] = w1;
      v.prog[2] = w2;
      v.prog[3] = w3;
      v.rd      = 5'(rd);
      v.val     = val;
      v.ret     = 32'(ret);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_reg(input string name, input int r, input logic [31:0] exp);
      dbg_raddr = 5'(r);
      #1;
      check(name, dbg_rdata, exp);
   endtask

   task automatic do_reset();
      run     = 1'b0;
      ld_we   = 1'b0;
      reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic load(input logic sel, input int addr, input logic [31:0] data);
      ld_sel   = sel;
      ld_addr  = 10'(addr);
      ld_wdata = data;
      ld_we    = 1'b1;
      @(negedge clock);
      ld_we    = 1'b0;
   endtask

   task automatic run_to_halt(input int budget, output int cycles);
      cycles = 0;
      run    = 1'b1;
      while (!halted && cycles < budget) begin
         @(negedge clock);
         cycles++;
      end
      run = 1'b0;
      check("halt_reached", 32'(halted), 32'd1);
   endtask

   // WD scoreboard: one expected value per WB, compared the negedge after WB commits.
   always @(negedge clock) begin
      if (sb_en && wb_seen) begin
         if (wd_q.size() == 0) check("wd_sb_underflow", 32'(wd_q.size()), 32'd1);
         else                  check("wd_sb", WD, wd_q.pop_front());
      end
      wb_seen = sb_en && (state == 3'd5);
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(ii(8,0,1,5), HW, HW, HW, 1, 32'd5, 1);
      vecs[1]  = mk(ii(8,0,8,-1), ii(8,0,9,1), ri(42,8,9,10), HW, 10, 32'd1, 3);
      vecs[2]  = mk(ii(8,0,0,5), HW, HW, HW, 0, 32'd0, 1);
      vecs[3]  = mk(ii(8,0,1,-1), ri(32,1,1,2), HW, HW, 2, 32'hFFFF_FFFE, 2);
      vecs[4]  = mk(ii(8,0,1,3), ii(8,0,2,5), ri(34,1,2,3), HW, 3, 32'hFFFF_FFFE, 3);
      vecs[5]  = mk(ii(8,0,1,12), ii(8,0,2,10), ri(37,1,2,3), HW, 3, 32'd14, 3);
      vecs[6]  = mk(ii(8,0,1,12), ii(8,0,2,10), ri(36,1,2,3), HW, 3, 32'd8, 3);
      vecs[7]  = mk(ii(8,0,1,1), ii(5,1,0,1), ii(8,0,2,9), HW, 2, 32'd0, 2);
      vecs[8]  = mk(ii(8,0,1,1), ii(4,1,0,1), ii(8,0,2,9), HW, 2, 32'd9, 3);
      vecs[9]  = mk(ii(8,0,2,7), ii(8,0,1,-1), ri(42,0,1,2), HW, 2, 32'd0, 3);
      vecs[10] = mk(ii(8,0,1,16'h1234), ii(16'h2B,0,1,8), ii(16'h23,0,2,8), HW, 2, 32'h1234, 3);
      vecs[11] = mk(ii(8,0,1,1), 32'h0, ii(8,0,1,2), HW, 1, 32'd1, 1);

      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      do_reset();

      // Swap program with WD scoreboard.
      load(1'b1, 0, 32'd5);
      load(1'b1, 1, 32'd7);
      load(1'b0, 0, ii(16'h23,0,8,0));
      load(1'b0, 1, ii(16'h23,0,9,4));
      load(1'b0, 2, ri(42,8,9,10));
      load(1'b0, 3, ii(4,10,0,2));
      load(1'b0, 4, ii(16'h2B,0,8,4));
      load(1'b0, 5, ii(16'h2B,0,9,0));
      load(1'b0, 6, ii(16'h23,0,11,0));
      load(1'b0, 7, ii(16'h23,0,12,4));
      load(1'b0, 8, ri(34,11,12,11));
      load(1'b0, 9, HW);
      wd_q  = '{32'd5, 32'd7, 32'd1, 32'd7, 32'd5, 32'd2};
      sb_en = 1'b1;
      run_to_halt(200, cyc);
      sb_en = 1'b0;
      check("swap_wd_left", 32'(wd_q.size()), 32'd0);
      check_reg("swap_r11", 11, 32'd2);
      check("swap_retired", retired, 32'd9);
      check("swap_halted", 32'(halted), 32'd1);
      do_reset();
      check("rst2_IR", IR, 32'd0);
      check("rst2_WD", WD, 32'd0);
      check("rst2_retired", retired, 32'd0);
      check_reg("rst2_r11", 11, 32'd0);
      load(1'b0, 0, ii(16'h23,0,1,0));
      load(1'b0, 1, ii(16'h23,0,2,4));
      load(1'b0, 2, HW);
      run_to_halt(100, cyc);
      check_reg("swap_dmem0", 1, 32'd7);
      check_reg("swap_dmem1", 2, 32'd5);

      // Table of short programs, expectations queued at launch and popped at halt.
      for (int i = 0; i < 12; i++) begin
         do_reset();
         for (int w = 0; w < 4; w++) load(1'b0, w, vecs[i].prog[w]);
         load(1'b0, 4, HW);
         exp_q.push_back(vecs[i]);
         run_to_halt(200, cyc);
         e = exp_q.pop_front();
         check_reg($sformatf("vec%0d_reg", i), int'(e.rd), e.val);
         check($sformatf("vec%0d_retired", i), retired, e.ret);
      end

      // Per-state sequence: lw 5, addi 4, sw 4, beq 3 cycles, then halt word.
      do_reset();
      load(1'b1, 0, 32'h40);
      load(1'b0, 0, ii(16'h23,0,1,0));
      load(1'b0, 1, ii(8,1,2,1));
      load(1'b0, 2, ii(16'h2B,0,2,4));
      load(1'b0, 3, ii(4,0,0,0));
      load(1'b0, 4, HW);
      st_q = '{1,2,3,4,5, 1,2,3,5, 1,2,3,4, 1,2,3, 1,2,6};
      run = 1'b1;
      for (int k = 0; st_q.size() > 0; k++) begin
         @(negedge clock);
         check($sformatf("seq_state%0d", k), 32'(state), 32'(st_q.pop_front()));
      end
      run = 1'b0;
      check_reg("seq_r2", 2, 32'h41);
      check("seq_retired", retired, 32'd4);

      // run dropped mid-instruction, plus a load attempt outside IDLE/HALT.
      do_reset();
      load(1'b0, 0, ii(8,0,1,3));
      load(1'b0, 1, ii(8,1,1,1));
      load(1'b0, 2, HW);
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;
      check("drop_fetch", 32'(state), 32'd1);
      @(negedge clock);
      load(1'b0, 1, HW);
      @(negedge clock);
      @(negedge clock);
      check("drop_idle", 32'(state), 32'd0);
      check("drop_retired", retired, 32'd1);
      check("drop_pc", pc, 32'd4);
      check_reg("drop_r1", 1, 32'd3);
      run_to_halt(100, cyc);
      check_reg("resume_r1", 1, 32'd4);
      check("resume_retired", retired, 32'd2);

      // lw at 4*DMEM_WORDS halts without writing rt.
      do_reset();
      load(1'b0, 0, ii(8,0,5,77));
      load(1'b0, 1, ii(16'h23,0,5,16'h1000));
      load(1'b0, 2, HW);
      run_to_halt(50, cyc);
      check("baddmem_latency_ok", 32'(cyc <= 9), 32'd1);
      check_reg("baddmem_r5", 5, 32'd77);
      check("baddmem_retired", retired, 32'd1);

      // Branch to pc = 4*IMEM_WORDS: FETCH halts and IR keeps the branch.
      do_reset();
      load(1'b0, 0, ii(4,0,0,1023));
      run_to_halt(50, cyc);
      check("fetch_oob_pc", pc, 32'd4096);
      check("fetch_oob_IR", IR, ii(4,0,0,1023));
      check("fetch_oob_retired", retired, 32'd1);

      // Reset during MEM of sw leaves DMEM untouched.
      do_reset();
      load(1'b1, 3, 32'h11);
      load(1'b0, 0, ii(8,0,1,16'h22));
      load(1'b0, 1, ii(16'h2B,0,1,12));
      load(1'b0, 2, HW);
      run = 1'b1;
      cyc = 0;
      while (state != 3'd4 && cyc < 40) begin
         @(negedge clock);
         cyc++;
      end
      check("midrst_reached_mem", 32'(state), 32'd4);
      reset_n = 1'b0;
      run     = 1'b0;
      #1;
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_pc", pc, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      load(1'b0, 0, ii(16'h23,0,2,12));
      load(1'b0, 1, HW);
      run_to_halt(50, cyc);
      check_reg("midrst_dmem3", 2, 32'h11);

      // Jump.
      do_reset();
      load(1'b0, 0, {6'h02, 26'h10});
      load(1'b0, 16, HW);
      run = 1'b1;
`ifdef MIPS_JUMP_EN
      repeat (4) @(negedge clock);
      check("jump_pc", pc, 32'h40);
      check("jump_state", 32'(state), 32'd1);
      run_to_halt(50, cyc);
      check("jump_retired", retired, 32'd1);
`else
      repeat (3) @(negedge clock);
      run = 1'b0;
      check("jump_halted", 32'(halted), 32'd1);
      check("jump_retired", retired, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
